// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: PC sequencing and one-entry fetch buffer with redirect, halt and transfer counting.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] Addr,
    input  logic [31:0] Inst,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Halt,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInst,
    output logic [31:0] OutPC,
    output logic        Halted,
    output logic [31:0] FetchCount
);
    typedef enum logic {RUN, HALT} state_t;
    state_t      state, state_n;
    logic [31:0] pc, pc_n, inst_n, opc_n, count_n;
    logic        valid_n, xfer, fetch;
    assign Addr   = pc;
    assign Halted = (state == HALT);
    always_comb begin
        xfer    = OutValid & OutReady;
        fetch   = !Redirect && !Halt && state == RUN && (!OutValid || OutReady);
        pc_n    = Redirect ? (RedirectPC & 32'hFFFFFFFC) : fetch ? pc + 32'd4 : pc;
        // a redirect flushes the entry even if it transfers this cycle
        valid_n = Redirect ? 1'b0 : fetch ? 1'b1 : xfer ? 1'b0 : OutValid;
        inst_n  = fetch ? Inst : OutInst;
        opc_n   = fetch ? pc : OutPC;
        state_n = Redirect ? RUN : (state == RUN && Halt) ? HALT : state;
        count_n = FetchCount + {31'd0, xfer};
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc         <= RESET_PC;
            OutValid   <= 1'b0;
            OutInst    <= 32'd0;
            OutPC      <= 32'd0;
            FetchCount <= 32'd0;
            state      <= RUN;
        end else begin
            pc         <= pc_n;
            OutValid   <= valid_n;
            OutInst    <= inst_n;
            OutPC      <= opc_n;
            FetchCount <= count_n;
            state      <= state_n;
        end
    end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: vector table for cycle-level outputs plus a transfer scoreboard.
module tb_inst_fetch_ctrl;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Addr, Inst, RedirectPC = 32'd0, OutInst, OutPC, FetchCount;
    logic        Redirect = 1'b0, Halt = 1'b0, OutValid, OutReady = 1'b0, Halted;
    logic [31:0] rom [256];
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic        rst, red;
        logic [31:0] rpc;
        logic        halt, rdy, x;
        logic [31:0] xi, xpc;
        logic        v;
        logic [31:0] inst, opc, addr;
        logic        hl;
        logic [31:0] cnt;
    } row_t;
    typedef struct {
        logic [31:0] inst, pc;
    } xfer_t;
    row_t  rows[$];
    xfer_t sb[$];

    inst_fetch_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .Inst(Inst), .Redirect(Redirect),
        .RedirectPC(RedirectPC), .Halt(Halt), .OutValid(OutValid), .OutReady(OutReady),
        .OutInst(OutInst), .OutPC(OutPC), .Halted(Halted), .FetchCount(FetchCount)
    );

    always #5 Clk = ~Clk;
    assign Inst = rom[Addr[9:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // transfer monitor: sampled mid-cycle, the handshake seen here completes at the next edge
    always @(negedge Clk) begin
        if (!Reset && OutValid === 1'b1 && OutReady) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got transfer of pc %h, expected none", OutPC);
            end else begin
                xfer_t e;
                e = sb.pop_front();
                chk("sb_inst", OutInst, e.inst);
                chk("sb_pc", OutPC, e.pc);
            end
        end
    end

    localparam logic [31:0] W0 = 32'h00430820, W1 = 32'h00232022, W2 = 32'h00294023,
                            W3 = 32'h3426800A, W4 = 32'h0025182A, WF = 32'hC0DE00FF,
                            W5 = 32'hC0DE0005;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hC0DE0000 + i;
        rom[0] = W0; rom[1] = W1; rom[2] = W2; rom[3] = W3; rom[4] = W4;
        //          rst red rpc           hlt rdy x  xi  xpc           v  inst opc           addr          hl cnt
        rows.push_back('{1, 0, 0,            0, 1, 0, 0,  0,            0, 0,  0,            0,            0, 0});
        rows.push_back('{0, 0, 0,            0, 1, 0, 0,  0,            1, W0, 0,            4,            0, 0});
        rows.push_back('{0, 0, 0,            0, 1, 1, W0, 0,            1, W1, 4,            8,            0, 1});
        rows.push_back('{0, 0, 0,            0, 1, 1, W1, 4,            1, W2, 8,            'hC,          0, 2});
        rows.push_back('{0, 0, 0,            0, 1, 1, W2, 8,            1, W3, 'hC,          'h10,         0, 3});
        rows.push_back('{0, 0, 0,            0, 1, 1, W3, 'hC,          1, W4, 'h10,         'h14,         0, 4});
        rows.push_back('{0, 0, 0,            0, 1, 1, W4, 'h10,         1, W5, 'h14,         'h18,         0, 5});
        rows.push_back('{0, 1, 4,            0, 0, 0, 0,  0,            0, W5, 'h14,         4,            0, 5});
        rows.push_back('{0, 0, 0,            0, 0, 0, 0,  0,            1, W1, 4,            8,            0, 5});
        rows.push_back('{0, 0, 0,            0, 0, 0, 0,  0,            1, W1, 4,            8,            0, 5});
        rows.push_back('{0, 0, 0,            0, 0, 0, 0,  0,            1, W1, 4,            8,            0, 5});
        rows.push_back('{0, 0, 0,            0, 0, 0, 0,  0,            1, W1, 4,            8,            0, 5});
        rows.push_back('{0, 0, 0,            0, 1, 1, W1, 4,            1, W2, 8,            'hC,          0, 6});
        rows.push_back('{0, 1, 'hE,          0, 0, 0, 0,  0,            0, W2, 8,            'hC,          0, 6});
        rows.push_back('{0, 0, 0,            0, 0, 0, 0,  0,            1, W3, 'hC,          'h10,         0, 6});
        rows.push_back('{0, 0, 0,            1, 1, 1, W3, 'hC,          0, W3, 'hC,          'h10,         1, 7});
        rows.push_back('{0, 0, 0,            0, 1, 0, 0,  0,            0, W3, 'hC,          'h10,         1, 7});
        rows.push_back('{0, 0, 0,            1, 1, 0, 0,  0,            0, W3, 'hC,          'h10,         1, 7});
        rows.push_back('{0, 1, 0,            0, 1, 0, 0,  0,            0, W3, 'hC,          0,            0, 7});
        rows.push_back('{0, 0, 0,            0, 1, 0, 0,  0,            1, W0, 0,            4,            0, 7});
        rows.push_back('{0, 1, 8,            1, 1, 1, W0, 0,            0, W0, 0,            8,            0, 8});
        rows.push_back('{0, 0, 0,            0, 1, 0, 0,  0,            1, W2, 8,            'hC,          0, 8});
        rows.push_back('{0, 0, 0,            1, 1, 1, W2, 8,            0, W2, 8,            'hC,          1, 9});
        rows.push_back('{0, 1, 4,            1, 1, 0, 0,  0,            0, W2, 8,            4,            0, 9});
        rows.push_back('{0, 0, 0,            0, 0, 0, 0,  0,            1, W1, 4,            8,            0, 9});
        rows.push_back('{1, 1, 'h40,         1, 0, 0, 0,  0,            0, 0,  0,            0,            0, 0});
        rows.push_back('{0, 0, 0,            0, 0, 0, 0,  0,            1, W0, 0,            4,            0, 0});
        rows.push_back('{1, 0, 0,            0, 1, 0, 0,  0,            0, 0,  0,            0,            0, 0});
        rows.push_back('{0, 1, 'hFFFFFFFC,   0, 1, 0, 0,  0,            0, 0,  0,            'hFFFFFFFC,   0, 0});
        rows.push_back('{0, 0, 0,            0, 1, 0, 0,  0,            1, WF, 'hFFFFFFFC,   0,            0, 0});
        rows.push_back('{0, 0, 0,            0, 1, 1, WF, 'hFFFFFFFC,   1, W0, 0,            4,            0, 1});
        rows.push_back('{0, 0, 0,            0, 1, 1, W0, 0,            1, W1, 4,            8,            0, 2});
        foreach (rows[i]) begin
            row_t r;
            r = rows[i];
            Reset = r.rst; Redirect = r.red; RedirectPC = r.rpc; Halt = r.halt; OutReady = r.rdy;
            if (r.x) sb.push_back('{r.xi, r.xpc});
            @(posedge Clk);
            #1;
            chk($sformatf("row%0d valid", i), {31'd0, OutValid}, {31'd0, r.v});
            chk($sformatf("row%0d inst", i), OutInst, r.inst);
            chk($sformatf("row%0d outpc", i), OutPC, r.opc);
            chk($sformatf("row%0d addr", i), Addr, r.addr);
            chk($sformatf("row%0d halted", i), {31'd0, Halted}, {31'd0, r.hl});
            chk($sformatf("row%0d count", i), FetchCount, r.cnt);
        end
        chk("sb_leftover", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the PC loaded on reset.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Addr, output, 32, the byte address presented to the instruction ROM; the ROM indexes by Addr[9:2] and reads combinationally.
REQ-005 SHALL have port Inst, input, 32, the ROM read data for Addr in the same cycle.
REQ-006 SHALL have port Redirect, input, 1, the branch/jump request.
REQ-007 SHALL have port RedirectPC, input, 32, the redirect target.
REQ-008 SHALL have port Halt, input, 1, the stop-fetch request.
REQ-009 SHALL have port OutValid, output, 1, meaning OutInst/OutPC hold a fetched instruction.
REQ-010 SHALL have port OutReady, input, 1, consumer accept; a transfer occurs on any cycle with OutValid&OutReady.
REQ-011 SHALL have port OutInst, output, 32, the fetched instruction word.
REQ-012 SHALL have port OutPC, output, 32, the address OutInst was fetched from.
REQ-013 SHALL have port Halted, output, 1, high while the FSM is in HALT.
REQ-014 SHALL have port FetchCount, output, 32, the number of completed transfers since reset.

Function
REQ-015 SHALL hold the internal registers PC (32), a one-entry output register (OutValid/OutInst/OutPC), FetchCount, and a 2-state FSM {RUN, HALT}.
REQ-016 SHALL drive Addr = PC combinationally at all times, including in HALT.
REQ-017 SHALL treat the slot as free in a cycle when !OutValid | OutReady.
REQ-018 SHALL fetch in RUN when the slot is free and Redirect=0 and Halt=0: OutInst<=Inst, OutPC<=PC, OutValid<=1, PC<=PC+4. Latency is 1 cycle from Addr to OutValid.
REQ-019 SHALL stall on OutValid&!OutReady: PC, OutInst, OutPC and OutValid are held unchanged and stable.
REQ-020 SHALL clear OutValid on a transfer with no fetch in the same cycle.
REQ-021 SHALL handle Redirect=1 in any state, with priority over Halt, stall and fetch: PC<=RedirectPC & 32'hFFFFFFFC, OutValid<=0 (entry flushed, even if OutReady=1), state<=RUN, and no fetch in that cycle.
REQ-022 SHALL count a transfer in FetchCount if OutValid&OutReady occurs in the same cycle as a Redirect, because the consumer saw it.
REQ-023 SHALL, on Halt=1 with Redirect=0 in RUN, set state<=HALT and perform no fetch that cycle; PC is unchanged.
REQ-024 SHALL let the output register still drain in HALT: transfers complete, but no new fetch occurs.
REQ-025 SHALL ignore Halt while in HALT; only Redirect or Reset exits HALT.
REQ-026 SHALL compute PC+4 modulo 2^32: 32'hFFFFFFFC wraps to 0. Addr 32'h400 aliases ROM index 0, which is legal and not detected.
REQ-027 SHALL increment FetchCount by 1 on each transfer, modulo 2^32.

Reset
REQ-028 SHALL, when Reset=1 at a rising edge, set PC<=RESET_PC, OutValid<=0, OutInst<=0, OutPC<=0, FetchCount<=0, state<=RUN, with Reset overriding Redirect and Halt.
REQ-029 SHALL, on Reset asserted mid-stall or mid-HALT, discard the held entry without transferring it.
REQ-030 SHALL perform the first fetch on the first edge with Reset=0, giving OutValid=1 and OutPC=RESET_PC one cycle after reset release.

Verification
REQ-031 SHALL cover streaming: bench ROM words[0..4]=00430820, 00232022, 00294023, 3426800A, 0025182A, with OutReady=1 held after reset. Required: OutInst sequence 00430820, 00232022, 00294023, 3426800A, 0025182A on consecutive cycles, OutPC 0,4,8,C,10, and FetchCount=5 after 5 transfers.
REQ-032 SHALL cover backpressure: OutReady=0 for 3 cycles while OutInst=00232022. Required: OutInst, OutPC=4 and Addr=8 are stable for those 3 cycles, then 00294023 follows one cycle after OutReady=1.
REQ-033 SHALL cover a redirect with flush: Redirect=1, RedirectPC=32'h0000000E while OutValid=1 and OutReady=0. Required: next cycle OutValid=0 and Addr=0C, then OutInst=3426800A with OutPC=0C, and FetchCount unchanged.
REQ-034 SHALL cover Halt then drain then resume: Halt=1 for one cycle with OutReady=1. Required: Halted=1, the held entry transfers, then OutValid stays 0 and Addr is frozen. A later Redirect to 0 gives Halted=0 and OutInst=00430820.
REQ-035 SHALL cover simultaneous events: Redirect=1 and Halt=1 in the same cycle results in Halted=0 and state RUN. Reset=1 with Redirect=1 results in PC=RESET_PC, OutValid=0 and FetchCount=0.
REQ-036 SHALL cover wrap: Redirect to 32'hFFFFFFFC with OutReady=1. Required: next fetch OutPC=FFFFFFFC, then Addr=0 and OutPC=0.
